// File: rtl/apb_v2.sv
// APB slave with a small register memory: three-state IDLE/SETUP/ACCESS handshake,
// Moore pready, write committed on ACCESS exit, read data registered on SETUP->ACCESS.
module apb_v2 #(
   parameter int addr_width = 2,
   parameter int mem_width  = 4,
   parameter int mem_depth  = 4
) (
   input  logic                  prst,
   input  logic                  pclk,
   input  logic                  pwrite,
   input  logic                  penable,
   input  logic [mem_width-1:0]  pwdata,
   input  logic [addr_width-1:0] paddr,
   output logic                  pready,
   output logic [mem_width-1:0]  prdata,
   input  logic                  psel
);

   localparam int unsigned DEPTH = mem_depth;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [mem_width-1:0] prdata_q, prdata_d;
   logic [mem_width-1:0] mem_q [DEPTH];
   logic [mem_width-1:0] mem_d [DEPTH];

   logic                 addr_ok;
   logic [mem_width-1:0] rd_word;
   logic                 wr_en;
   logic                 rd_en;

   // Out-of-range addresses read as zero and never match a write slot.
   always_comb begin
      addr_ok = (32'(paddr) < DEPTH);
      rd_word = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (32'(paddr) == i) begin
            rd_word = mem_q[i];
         end
      end
   end

   always_comb begin
      wr_en = (state_q == ACCESS) && psel && penable && pwrite && addr_ok;
      rd_en = (state_q == SETUP) && psel && penable && !pwrite;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (psel) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (psel) begin
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      prdata_d = prdata_q;
      if (rd_en) begin
         prdata_d = addr_ok ? rd_word : '0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en && (32'(paddr) == i)) begin
            mem_d[i] = pwdata;
         end
      end
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state_q  <= IDLE;
         prdata_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         prdata_q <= prdata_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign pready = (state_q == ACCESS);
   assign prdata = prdata_q;

endmodule

// File: tb/tb_apb_v2.sv
// Directed bench for apb_v2: the driver queues the expected prdata for each transfer,
// a negedge monitor pops and compares it whenever pready is seen.
module tb_apb_v2;

   logic       prst;
   logic       pclk;
   logic       pwrite;
   logic       penable;
   logic [3:0] pwdata;
   logic [1:0] paddr;
   logic       pready;
   logic [3:0] prdata;
   logic       psel;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sb_q[$];
   logic       prev_pready = 1'b0;

   apb_v2 dut (
      .prst    (prst),
      .pclk    (pclk),
      .pwrite  (pwrite),
      .penable (penable),
      .pwdata  (pwdata),
      .paddr   (paddr),
      .pready  (pready),
      .prdata  (prdata),
      .psel    (psel)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every pready cycle must match a queued transfer and last only one cycle.
   always @(negedge pclk) begin
      if (!prst) begin
         if (pready) begin
            chk("pready_single_cycle", int'(prev_pready), 0);
            if (sb_q.size() == 0) begin
               chk("unexpected_pready", 1, 0);
            end else begin
               chk("prdata_in_pready", int'(prdata), int'(sb_q.pop_front()));
            end
         end
         prev_pready <= pready;
      end else begin
         prev_pready <= 1'b0;
      end
   end

   // Drive one transfer starting now; returns #1 after the edge that leaves ACCESS.
   task automatic xfer(input logic w, input logic [1:0] a, input logic [3:0] d,
                       input logic [3:0] exp_rd, input logic drop, output int lat);
      sb_q.push_back(exp_rd);
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = w;
      paddr   = a;
      pwdata  = d;
      lat = 0;
      forever begin
         @(posedge pclk);
         #1;
         lat++;
         if (pready) break;
         if (lat > 8) begin
            chk("pready_timeout", lat, 2);
            break;
         end
      end
      if (drop) begin
         psel    = 1'b0;
         penable = 1'b0;
      end
      @(posedge pclk);
      #1;
   endtask

   task automatic idle_cycle();
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
   endtask

   logic [3:0] wr_data [4] = '{4'h3, 4'hD, 4'h5, 4'hC};
   int lat;
   int n;

   initial begin
      prst    = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      pwdata  = 4'h0;
      paddr   = 2'd0;
      #1;
      chk("reset_pready", int'(pready), 0);
      chk("reset_prdata", int'(prdata), 0);
      @(posedge pclk);
      #1;
      prst = 1'b0;

      // Idle after reset: nothing moves.
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         chk("idle_pready", int'(pready), 0);
         chk("idle_prdata", int'(prdata), 0);
      end
      @(posedge pclk);
      #1;

      // Unwritten address reads as zero.
      xfer(1'b0, 2'd0, 4'h0, 4'h0, 1'b0, lat);
      idle_cycle();

      // Single write then read of the same word, both from IDLE.
      xfer(1'b1, 2'd2, 4'hA, 4'h0, 1'b0, lat);
      chk("write_latency", lat, 2);
      idle_cycle();
      xfer(1'b0, 2'd2, 4'h0, 4'hA, 1'b0, lat);
      chk("read_latency", lat, 2);
      idle_cycle();

      // Back-to-back writes then reads; prdata holds 0xA across the writes.
      for (int i = 0; i < 4; i++) begin
         xfer(1'b1, 2'(i), wr_data[i], 4'hA, 1'b0, lat);
         chk("b2b_write_latency", lat, (i == 0) ? 2 : 1);
      end
      for (int i = 0; i < 4; i++) begin
         xfer(1'b0, 2'(i), 4'h0, wr_data[i], 1'b0, lat);
         chk("b2b_read_latency", lat, 1);
      end
      idle_cycle();

      // Write stalled in SETUP (penable low) must never complete.
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 2'd0;
      pwdata  = 4'h7;
      for (int i = 0; i < 4; i++) begin
         @(posedge pclk);
         #1;
         chk("stall_pready", int'(pready), 0);
      end
      idle_cycle();
      xfer(1'b0, 2'd0, 4'h0, 4'h3, 1'b0, lat);
      idle_cycle();

      // psel dropped during ACCESS: pulse still seen, no write, back to IDLE.
      xfer(1'b1, 2'd2, 4'h9, 4'h3, 1'b1, lat);
      chk("drop_pready_after", int'(pready), 0);
      xfer(1'b0, 2'd2, 4'h0, 4'h5, 1'b0, lat);
      chk("after_drop_latency", lat, 2);
      idle_cycle();

      // Reset during ACCESS of a write of 0xF to addr 1.
      xfer(1'b0, 2'd3, 4'h0, 4'hC, 1'b0, lat);
      idle_cycle();
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 2'd1;
      pwdata  = 4'hF;
      n = 0;
      while (!pready && n < 8) begin
         @(posedge pclk);
         #1;
         n++;
      end
      chk("rst_xfer_reached_access", int'(pready), 1);
      prst = 1'b1;
      #1;
      chk("midrst_pready", int'(pready), 0);
      chk("midrst_prdata", int'(prdata), 0);
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
      prst = 1'b0;
      @(posedge pclk);
      #1;
      xfer(1'b0, 2'd1, 4'h0, 4'h0, 1'b0, lat);
      xfer(1'b0, 2'd3, 4'h0, 4'h0, 1'b0, lat);
      idle_cycle();
      repeat (3) @(posedge pclk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/apb_v2.md
APB_V2 -- requirements
Module: apb_v2

Interface
REQ-001 Parameter addr_width, default 2, width of paddr.
REQ-002 Parameter mem_width, default 4, width of pwdata/prdata and of each memory word.
REQ-003 Parameter mem_depth, default 4, number of memory words.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 prst  input  1  asynchronous active-high reset.
REQ-006 pclk  input  1  clock; all state updates on rising edge.
REQ-007 pwrite  input  1  1 = write transfer, 0 = read transfer.
REQ-008 penable  input  1  APB enable (access phase).
REQ-009 pwdata  input  mem_width  write data.
REQ-010 paddr  input  addr_width  word address.
REQ-011 pready  output  1  transfer-complete strobe.
REQ-012 prdata  output  mem_width  registered read data.
REQ-013 psel  input  1  slave select.
REQ-014 Port order SHALL be prst, pclk, pwrite, penable, pwdata, paddr, pready, prdata, psel.

Function
REQ-015 Block SHALL be an APB slave with an internal mem_depth x mem_width register memory.
REQ-016 FSM SHALL have three states: IDLE, SETUP, ACCESS, held in a registered state variable.
REQ-017 IDLE: go to SETUP when psel=1; otherwise stay in IDLE.
REQ-018 SETUP: go to ACCESS when psel=1 and penable=1; go to IDLE when psel=0; otherwise stay in SETUP.
REQ-019 ACCESS: go to SETUP when psel=1 at the clock edge (back-to-back transfer); otherwise go to IDLE.
REQ-020 pready SHALL be a Moore output: 1 only while in ACCESS, 0 in IDLE and SETUP.
REQ-021 Every transfer SHALL last at least 3 cycles from psel rising (IDLE, SETUP, ACCESS); each ACCESS cycle has exactly one pready pulse of 1 cycle.
REQ-022 Write: on the rising edge that leaves ACCESS, if psel=1, penable=1 and pwrite=1, mem[paddr] SHALL be loaded with pwdata.
REQ-023 Read: on the SETUP->ACCESS edge with pwrite=0, prdata SHALL be loaded with mem[paddr], so prdata is valid throughout the pready=1 cycle.
REQ-024 prdata SHALL hold its last value at all other times, including write transfers.
REQ-025 paddr >= mem_depth: writes SHALL be ignored, reads SHALL load prdata with 0; pready behaves normally.
REQ-026 psel or penable dropped while in ACCESS: pready still asserts for that cycle, no memory write occurs, FSM follows REQ-019.
REQ-027 A read of an address immediately after a write to it SHALL return the newly written value.
REQ-028 pwdata/paddr/pwrite changes in IDLE or SETUP SHALL have no effect on memory.

Reset
REQ-029 prst=1 SHALL immediately, without a clock, force state=IDLE, pready=0, prdata=0 and every memory word to 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no memory write; operation resumes from IDLE on the first rising edge after prst=0.

Verification
REQ-031 After reset, psel=penable=0 for 5 cycles -> pready=0, prdata=0 throughout.
REQ-032 Write 0xA to addr 2 (psel=penable=pwrite=1) -> pready=1 for exactly one cycle, 2 cycles after psel rises; subsequent read of addr 2 -> prdata=0xA during pready.
REQ-033 Write 0x3,0xD,0x5,0xC to addr 0..3 back-to-back, each held until pready=1, then read addr 0..3 -> prdata=0x3,0xD,0x5,0xC in the respective pready cycles.
REQ-034 Read of an unwritten address after reset -> prdata=0x0; write with psel=1, penable=0 held 4 cycles -> FSM stays in SETUP, pready=0, memory unchanged.
REQ-035 Assert prst during ACCESS of a write of 0xF to addr 1 -> pready=0 and prdata=0 at once, later read of addr 1 returns 0x0.
REQ-036 Deassert psel in ACCESS of a write -> one pready pulse, FSM returns to IDLE, memory unchanged.
